// File: rtl/boot_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// imem_we is a one-cycle strobe qualifying imem_addr/imem_wdata; there is no ready, so the memory accepts every strobe.
interface boot_loader_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/boot_loader.sv
// UART (8N1) program loader: length header, little-endian words into imem,
// holds the core in reset until the image is complete.
module boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  boot_loader_if.master      bus,
  output logic               core_rst,
  output logic               load_done,
  output logic               frame_err,
  output logic               byte_valid,
  output logic [1:0]         rx_state_dbg,
  output logic [1:0]         p_state_dbg
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_LEN0, P_LEN1, P_DATA, P_DONE} p_state_t;

  localparam int              CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]   FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]     DEPTH = 17'(1) << DEPTH_W;

  logic            rx_meta, rx_s, rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;

  p_state_t        p_state;
  logic [15:0]     n_words;
  logic [15:0]     word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;

  assign rx_state_dbg = rx_state;
  assign p_state_dbg  = p_state;

  // rx_prev lags rx_s by one cycle for start-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt      <= HALF;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              cnt      <= FULL;
              bit_idx  <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err  <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state        <= P_LEN0;
      n_words        <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      word_buf       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_rst       <= 1'b1;
      load_done      <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (p_state)
        P_LEN0: begin
          if (byte_valid) begin
            n_words[7:0] <= rx_byte;
            p_state      <= P_LEN1;
          end
        end
        P_LEN1: begin
          if (byte_valid) begin
            n_words[15:8] <= rx_byte;
            if ({rx_byte, n_words[7:0]} == 16'd0) begin
              p_state   <= P_DONE;
              core_rst  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              p_state <= P_DATA;
            end
          end
        end
        P_DATA: begin
          if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Words beyond memory depth still count toward N but never write
              if ({1'b0, word_idx} < DEPTH) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= {14'd0, word_idx, 2'b00};
                bus.imem_wdata <= {rx_byte, word_buf};
              end
              word_idx <= word_idx + 16'd1;
              if (word_idx + 16'd1 == n_words) p_state <= P_DONE;
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= rx_byte;
            end
          end
        end
        P_DONE: begin
          core_rst  <= 1'b0;
          load_done <= 1'b1;
        end
        default: p_state <= P_LEN0;
      endcase
    end
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader that sits upstream of the single-cycle core. It receives a program image over a UART line (8N1), assembles little-endian 32-bit words, writes them into instruction memory through a dedicated write port, and holds the core in reset until the image is complete. After loading, it releases the core and ignores the serial line until the next reset.

## Interface

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit; must be ≥ 8.
- DEPTH_W, 10: log2 of instruction memory depth in words.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial data; idles high; asynchronous to clk.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  32  byte address of the word being written; always word-aligned.
- imem_wdata  output  32  word being written.
- core_rst  output  1  reset to the core; high until loading completes.
- load_done  output  1  high once the image is fully loaded.
- frame_err  output  1  sticky flag for a stop-bit error.

## Operation

- **Synchronizer:** uart_rx passes through a 2-flop synchronizer. All logic uses the synchronized value `rx_s`.
- **Receiver FSM:** RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - RX_IDLE: a falling edge on `rx_s` enters RX_START and loads the bit counter with CLKS_PER_BIT/2.
  - RX_START: at mid-bit, if `rx_s` = 1 the start was a glitch; return to RX_IDLE. Otherwise go to RX_DATA.
  - RX_DATA: sample one bit every CLKS_PER_BIT, 8 bits, LSB first.
  - RX_STOP: at mid-stop-bit, if `rx_s` = 1, pulse `byte_valid` for one cycle. If `rx_s` = 0, set frame_err, discard the byte, and emit no `byte_valid`. Both cases return to RX_IDLE.
- **Protocol FSM:** P_LEN0 → P_LEN1 → P_DATA → P_DONE.
  - P_LEN0 / P_LEN1: take the 16-bit word count N, little-endian, low byte first. If N = 0, go directly from P_LEN1 to P_DONE.
  - P_DATA: take bytes into a 2-bit byte index, little-endian (byte 0 → bits 7:0). On the 4th byte:
    - drive imem_wdata with the assembled word and imem_addr = word_idx × 4;
    - pulse imem_we;
    - increment word_idx.
  - Out-of-range words: if word_idx ≥ 2^DEPTH_W, the word is still counted but imem_we is suppressed; it is dropped, with no wrap-around.
  - Leaving P_DATA: when word_idx reaches N after a word, go to P_DONE.
  - P_DONE: terminal until rst. Bytes received here are ignored.
- **Frame errors:** do not alter protocol state, byte index or word_idx. The byte is simply absent.
- **Reset mid-load:** rst at any point aborts everything.
  - core_rst reasserts immediately (asynchronously).
  - A fresh header is then required.
  - Words already written stay in memory but are not tracked.

## Timing

Reset values:
- imem_we = 0
- imem_addr = 0
- imem_wdata = 0
- core_rst = 1
- load_done = 0
- frame_err = 0
- both FSMs in their first state
- all counters = 0

Cycle-level behaviour:
- **Input latency:** 2 cycles from uart_rx to `rx_s`.
- **Byte latency:** `byte_valid` is high in the cycle after the mid-stop-bit sample edge.
- **Write timing:**
  - imem_we is high exactly one cycle, in the cycle after the `byte_valid` of the word's 4th byte.
  - imem_addr and imem_wdata are valid in that same cycle and hold until the next write.
- **Completion timing:**
  - load_done rises and core_rst falls together, in the cycle after the final imem_we, even if that write was suppressed.
  - For N = 0, this happens in the cycle after the `byte_valid` of the P_LEN1 byte.
  - Both then hold until rst.
- **frame_err:** set in the cycle after the bad stop sample.
- **Throughput:** at most one imem_we per 40 bit-times. There is no back-pressure; the memory must accept writes every cycle.

## Test plan

Directed scenarios, with CLKS_PER_BIT = 16 and DEPTH_W = 4:

1. **Two-word load.** Send bytes 02 00, 13 05 A0 00, 93 05 10 00.
   - imem_we at addr 0x0 with data 0x00A00513, then at addr 0x4 with data 0x00100593.
   - core_rst falls and load_done rises one cycle after the second write.
2. **Empty image.** Send header 00 00.
   - No imem_we.
   - core_rst = 0 one cycle after the 2nd byte_valid.
   - Bytes sent afterwards produce no writes.
3. **Framing error.** Header 01 00, then one byte with stop bit = 0, then 11 22 33 44.
   - frame_err = 1 and stays high.
   - Exactly one write: addr 0x0, data 0x44332211.
4. **Glitch rejection.** A 3-cycle low pulse on uart_rx while idle.
   - No byte_valid.
   - State unchanged.
   - frame_err = 0.
5. **Overflow.** Header 11 00 (N = 17) followed by 17 words.
   - 16 writes, at addresses 0x00–0x3C.
   - The 17th word is not written.
   - core_rst falls one cycle after the 17th word completes.
6. **Reset mid-load.** Assert rst midway through word 1 of a 3-word load.
   - core_rst = 1 immediately; all outputs return to reset values.
   - A subsequent full load writes from addr 0x0.
